prefetch_unit: RTL and testbench
================================

# prefetch_unit

Instruction prefetch queue directly upstream of `decoder`. It requests instruction words, assembles them from the serial reply stream `NSHIFT` bits per cycle, and buffers them in a small FIFO. It presents the head word as `inst`/`inst_valid`, owns the immediate register that feeds `imm_full`/`imm_data_in`, and serves `load_imm16` from the FIFO.

## Interface
Parameters:
- `REG_BITS`, 8: register width; words are `2*REG_BITS` = 16 bits.
- `NSHIFT`, 2: bits per serial beat; one word = `W_BEATS` = 16/`NSHIFT` = 8 beats.
- `QUEUE_WORDS`, 2: FIFO depth in words, minimum 2.

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `fetch_req` out 1: request to start a word fetch.
- `fetch_started` in 1: fetch accepted this cycle.
- `fetch_data_valid` in 1: reply beat present.
- `fetch_data` in `NSHIFT`: reply beat, LSB-first.
- `block_prefetch` in 1: suppresses new `fetch_req`.
- `write_pc` in 1: PC redirected; flush.
- `prefetch_idle` out 1: no request pending and no fetch in flight.
- `inst_valid` out 1: head word valid.
- `inst` out 16: head word.
- `inst_done` in 1: pop head.
- `load_imm16` in 1: move the word after head into the imm register.
- `imm16_loaded` out 1: one-cycle pulse when the load is complete.
- `imm_full` out 16: imm register.
- `imm_data_in` out `NSHIFT`: `imm_full[NSHIFT-1:0]`.
- `next_imm_data` in 1: rotate imm register right by `NSHIFT`.
- `feed_imm8` in 1: shift in scheduler data instead of rotating.
- `imm8_data_out` in `NSHIFT`: data shifted in when `feed_imm8` is high.

## Operation
- **Fetch FSM** has two states, IDLE and RECV.
  - `fetch_req` = IDLE && !`block_prefetch` && (occupancy + 0) < `QUEUE_WORDS`. It is combinational.
  - IDLE→RECV on `fetch_started`; the beat counter clears.
  - In RECV, each `fetch_data_valid` shifts `fetch_data` into the word register from the top (LSB-first word order) and increments the counter.
  - On beat `W_BEATS`-1 the assembled word is pushed, unless `drop` is set, and the FSM returns to IDLE.
- **Flush.** `write_pc` empties the FIFO and clears imm state.
  - If the FSM is in RECV, or `fetch_started` is high in the same cycle, `drop` is set.
  - The word in flight is then discarded at its last beat, and `drop` clears.
- **`prefetch_idle`** = IDLE && !`fetch_started`.
- **FIFO.** Head index plus count; indices wrap modulo `QUEUE_WORDS`.
  - Push and pop in the same cycle leaves the count unchanged.
  - When full, `fetch_req` is low, so a push never occurs on a full FIFO.
- **Issue.** When a word becomes head with `inst_valid` previously low, or on a pop that leaves a valid head, imm register ← {8'h00, new head[7:0]}.
- **`load_imm16`** is held high by the decoder until `imm16_loaded`.
  - When entry head+1 is valid: imm register ← that word, the entry is removed (head is kept), and `imm16_loaded` pulses on the next cycle.
  - `inst_done` together with `load_imm16` in one cycle is illegal (bench asserts).
- **Imm shift.** When `next_imm_data` || `feed_imm8`: imm ← {ins, imm[15:NSHIFT]}, where ins = `feed_imm8` ? `imm8_data_out` : imm[NSHIFT-1:0].
  - Priority: `write_pc` > load > issue > shift.

## Timing
- Reset values: `inst_valid`=0, `inst`=0, `imm_full`=0, `imm16_loaded`=0, FIFO empty, FSM IDLE, `drop`=0. Consequently `fetch_req`=!`block_prefetch` and `prefetch_idle`=1.
- Latency from last beat edge to `inst_valid` high (FIFO previously empty): 1 cycle.
- Pop: `inst` shows the next word in the cycle after `inst_done`.
- `write_pc`: `inst_valid` is low from the next cycle; `fetch_req` may reassert once the FSM is IDLE and `drop` has cleared.
- Beats arrive only in RECV; beats in IDLE are ignored.
- Reset mid-RECV: everything returns to reset values immediately (asynchronous).

## Structure
- `W_BEATS` and the counter width `$clog2(W_BEATS)` go in shared `common.vh` alongside the existing `TX`/`SRC` defines.
- One sub-module: `prefetch_fifo`, holding storage, head/count, push/pop/remove-second and a flush port.
- The FSM, imm register and flush logic stay in `prefetch_unit`.

## Test plan
- **Single fetch.** After reset, `fetch_started`, then 8 beats encoding 16'hA5C3 → `inst`=16'hA5C3, `inst_valid`=1 one cycle after the last beat, `imm_full`=16'h00C3.
- **Backpressure.** Fill 2 words with no `inst_done` → `fetch_req`=0. Pulse `inst_done` → `inst` becomes the second word and `fetch_req`=1.
- **Immediate load.** Queue 16'h1234, 16'hBEEF, then `load_imm16` → `imm_full`=16'hBEEF, one `imm16_loaded` pulse, `inst` still 16'h1234, FIFO count 1.
- **Flush mid-receive.** `write_pc` after 3 beats → the remaining beats are dropped, `inst_valid` stays 0, `prefetch_idle`=1 after the last beat.
- **Shift and feed.** imm=16'h00C3, 2 cycles of `next_imm_data` → `imm_data_in` sequence 2'b11, 2'b00. Then `feed_imm8` with 2'b10 → `imm_full[15:14]`=2'b10.
- **Async reset during push/pop.** Assert `reset_n` low in the same cycle as a push and pop → all outputs at reset values before the next edge.

Source files
------------

// File: rtl/prefetch_unit_pkg.sv
// Shared constants for the instruction prefetch queue: fetch FSM encodings
// and word/beat geometry helpers.
package prefetch_unit_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  function automatic int unsigned beats_per_word(input int unsigned word_bits,
                                                 input int unsigned nshift);
    return word_bits / nshift;
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Small circular word buffer: head index plus count, with pop, push,
// remove-second-entry and flush.
module prefetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             remove_second,
  output logic [WIDTH-1:0] head_data,
  output logic [WIDTH-1:0] second_data,
  output logic             head_valid,
  output logic             second_valid,
  output logic             full
);

  localparam int unsigned HW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [HW-1:0]    head;
  logic [CW-1:0]    cnt;

  function automatic logic [HW-1:0] wrap(input logic [HW-1:0] base,
                                         input int unsigned off);
    return HW'((32'(base) + off) % DEPTH);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
      cnt  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head <= '0;
      cnt  <= '0;
    end else begin
      if (push) mem[wrap(head, 32'(cnt))] <= push_data;
      if (pop) begin
        head <= wrap(head, 1);
        if (!push) cnt <= cnt - 1'b1;
      end else if (remove_second) begin
        // Drop entry head+1 by copying the head forward and advancing head.
        mem[wrap(head, 1)] <= mem[head];
        head <= wrap(head, 1);
        if (!push) cnt <= cnt - 1'b1;
      end else if (push) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign head_data    = mem[head];
  assign second_data  = mem[wrap(head, 1)];
  assign head_valid   = (cnt != '0);
  assign second_valid = (cnt >= CW'(2));
  assign full         = (cnt == CW'(DEPTH));

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch queue: serial word fetch FSM, word FIFO, and the
// immediate register feeding the decoder.
module prefetch_unit #(
  parameter int unsigned REG_BITS    = 8,
  parameter int unsigned NSHIFT      = 2,
  parameter int unsigned QUEUE_WORDS = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  fetch_req,
  input  logic                  fetch_started,
  input  logic                  fetch_data_valid,
  input  logic [NSHIFT-1:0]     fetch_data,
  input  logic                  block_prefetch,
  input  logic                  write_pc,
  output logic                  prefetch_idle,
  output logic                  inst_valid,
  output logic [2*REG_BITS-1:0] inst,
  input  logic                  inst_done,
  input  logic                  load_imm16,
  output logic                  imm16_loaded,
  output logic [2*REG_BITS-1:0] imm_full,
  output logic [NSHIFT-1:0]     imm_data_in,
  input  logic                  next_imm_data,
  input  logic                  feed_imm8,
  input  logic [NSHIFT-1:0]     imm8_data_out
);
  import prefetch_unit_pkg::*;

  localparam int unsigned WORD_BITS = 2 * REG_BITS;
  localparam int unsigned W_BEATS   = beats_per_word(WORD_BITS, NSHIFT);
  localparam int unsigned CNT_W     = $clog2(W_BEATS);

  logic [0:0]           state;
  logic [CNT_W-1:0]     beat_cnt;
  logic [WORD_BITS-1:0] word_sr;
  logic [WORD_BITS-1:0] assembled;
  logic [WORD_BITS-1:0] imm;
  logic [WORD_BITS-1:0] head_data;
  logic [WORD_BITS-1:0] second_data;
  logic [WORD_BITS-1:0] new_head;
  logic                 drop;
  logic                 in_recv, last_beat, push, pop, load_fire, remove, issue;
  logic                 head_valid, second_valid, full;

  assign in_recv   = (state == ST_RECV);
  assign last_beat = in_recv && fetch_data_valid && (beat_cnt == CNT_W'(W_BEATS - 1));
  assign assembled = {fetch_data, word_sr[WORD_BITS-1:NSHIFT]};
  assign push      = last_beat && !drop && !write_pc;
  assign pop       = inst_done && head_valid;
  assign load_fire = load_imm16 && second_valid && !imm16_loaded;
  assign remove    = load_fire && !pop;
  // A new head appears either on first arrival into an empty queue or on a
  // pop that leaves something behind (the second entry, or the word landing now).
  assign issue     = (!head_valid && push) || (pop && (second_valid || push));
  assign new_head  = (pop && second_valid) ? second_data : assembled;

  prefetch_fifo #(
    .DEPTH(QUEUE_WORDS),
    .WIDTH(WORD_BITS)
  ) u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (write_pc),
    .push         (push),
    .push_data    (assembled),
    .pop          (pop),
    .remove_second(remove),
    .head_data    (head_data),
    .second_data  (second_data),
    .head_valid   (head_valid),
    .second_valid (second_valid),
    .full         (full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      word_sr  <= '0;
    end else if (!in_recv) begin
      if (fetch_started) begin
        state    <= ST_RECV;
        beat_cnt <= '0;
      end
    end else if (fetch_data_valid) begin
      word_sr  <= assembled;
      beat_cnt <= beat_cnt + 1'b1;
      if (last_beat) state <= ST_IDLE;
    end
  end

  // A flush coinciding with the last beat needs no drop: that word is
  // already suppressed by the flush itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop <= 1'b0;
    end else if (write_pc && ((in_recv && !last_beat) || (!in_recv && fetch_started))) begin
      drop <= 1'b1;
    end else if (last_beat) begin
      drop <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      imm          <= '0;
      imm16_loaded <= 1'b0;
    end else if (write_pc) begin
      imm          <= '0;
      imm16_loaded <= 1'b0;
    end else begin
      imm16_loaded <= load_fire;
      if (load_fire) begin
        imm <= second_data;
      end else if (issue) begin
        imm <= {{REG_BITS{1'b0}}, new_head[REG_BITS-1:0]};
      end else if (next_imm_data || feed_imm8) begin
        imm <= {(feed_imm8 ? imm8_data_out : imm[NSHIFT-1:0]), imm[WORD_BITS-1:NSHIFT]};
      end
    end
  end

  assign fetch_req     = !in_recv && !block_prefetch && !full;
  assign prefetch_idle = !in_recv && !fetch_started;
  assign inst_valid    = head_valid;
  assign inst          = head_valid ? head_data : '0;
  assign imm_full      = imm;
  assign imm_data_in   = imm[NSHIFT-1:0];

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit: fetch, backpressure, imm load/shift,
// flush mid-receive and asynchronous reset.
module tb_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_req;
  logic        fetch_started;
  logic        fetch_data_valid;
  logic [1:0]  fetch_data;
  logic        block_prefetch;
  logic        write_pc;
  logic        prefetch_idle;
  logic        inst_valid;
  logic [15:0] inst;
  logic        inst_done;
  logic        load_imm16;
  logic        imm16_loaded;
  logic [15:0] imm_full;
  logic [1:0]  imm_data_in;
  logic        next_imm_data;
  logic        feed_imm8;
  logic [1:0]  imm8_data_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prefetch_unit #(
    .REG_BITS(8),
    .NSHIFT(2),
    .QUEUE_WORDS(2)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .fetch_req       (fetch_req),
    .fetch_started   (fetch_started),
    .fetch_data_valid(fetch_data_valid),
    .fetch_data      (fetch_data),
    .block_prefetch  (block_prefetch),
    .write_pc        (write_pc),
    .prefetch_idle   (prefetch_idle),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_done       (inst_done),
    .load_imm16      (load_imm16),
    .imm16_loaded    (imm16_loaded),
    .imm_full        (imm_full),
    .imm_data_in     (imm_data_in),
    .next_imm_data   (next_imm_data),
    .feed_imm8       (feed_imm8),
    .imm8_data_out   (imm8_data_out)
  );

  always @(posedge clk) begin
    assert (!(inst_done && load_imm16)) else begin
      errors++;
      $error("FAIL illegal_done_with_load: observed 1 expected 0");
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fetch();
    for (int i = 0; i < 20 && !fetch_req; i++) tick();
    chk("fetch_req_wait", 32'(fetch_req), 32'd1);
    fetch_started = 1'b1;
    tick();
    fetch_started = 1'b0;
  endtask

  task automatic beats(input logic [15:0] w, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      fetch_data_valid = 1'b1;
      fetch_data       = w[2*i +: 2];
      tick();
    end
    fetch_data_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    start_fetch();
    beats(w, 0, 8);
  endtask

  initial begin
    reset_n = 1'b0; fetch_started = 0; fetch_data_valid = 0; fetch_data = '0;
    block_prefetch = 0; write_pc = 0; inst_done = 0; load_imm16 = 0;
    next_imm_data = 0; feed_imm8 = 0; imm8_data_out = '0;
    #3;
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", 32'(inst), 32'h0);
    chk("rst_imm_full", 32'(imm_full), 32'h0);
    chk("rst_imm16_loaded", 32'(imm16_loaded), 32'd0);
    chk("rst_fetch_req", 32'(fetch_req), 32'd1);
    chk("rst_prefetch_idle", 32'(prefetch_idle), 32'd1);
    block_prefetch = 1'b1;
    #1;
    chk("rst_fetch_req_blocked", 32'(fetch_req), 32'd0);
    block_prefetch = 1'b0;
    #8 reset_n = 1'b1;
    tick();

    // Single fetch
    start_fetch();
    chk("recv_not_idle", 32'(prefetch_idle), 32'd0);
    beats(16'hA5C3, 0, 7);
    chk("pre_last_inst_valid", 32'(inst_valid), 32'd0);
    beats(16'hA5C3, 7, 1);
    chk("single_inst_valid", 32'(inst_valid), 32'd1);
    chk("single_inst", 32'(inst), 32'hA5C3);
    chk("single_imm", 32'(imm_full), 32'h00C3);
    chk("single_idle", 32'(prefetch_idle), 32'd1);

    // Shift and feed
    chk("shift_data0", 32'(imm_data_in), 32'h3);
    next_imm_data = 1'b1;
    tick();
    chk("shift_data1", 32'(imm_data_in), 32'h0);
    chk("shift_imm1", 32'(imm_full), 32'hC030);
    tick();
    chk("shift_imm2", 32'(imm_full), 32'h300C);
    next_imm_data = 1'b0;
    feed_imm8 = 1'b1; imm8_data_out = 2'b10;
    tick();
    feed_imm8 = 1'b0;
    chk("feed_top", 32'(imm_full[15:14]), 32'h2);
    chk("feed_imm", 32'(imm_full), 32'h8C03);

    // Backpressure
    send_word(16'h5A3C);
    chk("bp_fetch_req", 32'(fetch_req), 32'd0);
    chk("bp_head_kept", 32'(inst), 32'hA5C3);
    inst_done = 1'b1;
    tick();
    inst_done = 1'b0;
    chk("bp_pop_inst", 32'(inst), 32'h5A3C);
    chk("bp_pop_fetch_req", 32'(fetch_req), 32'd1);
    chk("bp_pop_imm", 32'(imm_full), 32'h003C);
    inst_done = 1'b1;
    tick();
    inst_done = 1'b0;
    chk("bp_empty", 32'(inst_valid), 32'd0);

    // Immediate load
    send_word(16'h1234);
    chk("ld_issue_imm", 32'(imm_full), 32'h0034);
    send_word(16'hBEEF);
    chk("ld_full", 32'(fetch_req), 32'd0);
    load_imm16 = 1'b1;
    tick();
    load_imm16 = 1'b0;
    chk("ld_pulse", 32'(imm16_loaded), 32'd1);
    chk("ld_imm", 32'(imm_full), 32'hBEEF);
    chk("ld_inst", 32'(inst), 32'h1234);
    tick();
    chk("ld_pulse_end", 32'(imm16_loaded), 32'd0);
    chk("ld_one_left", 32'(fetch_req), 32'd1);
    chk("ld_imm_hold", 32'(imm_full), 32'hBEEF);
    inst_done = 1'b1;
    tick();
    inst_done = 1'b0;
    chk("ld_count1_empty", 32'(inst_valid), 32'd0);

    // Flush mid-receive
    send_word(16'hC0DE);
    start_fetch();
    beats(16'h7777, 0, 3);
    write_pc = 1'b1;
    tick();
    write_pc = 1'b0;
    chk("fl_inst_valid", 32'(inst_valid), 32'd0);
    chk("fl_imm_clear", 32'(imm_full), 32'h0);
    chk("fl_no_req_recv", 32'(fetch_req), 32'd0);
    beats(16'h7777, 3, 5);
    chk("fl_dropped", 32'(inst_valid), 32'd0);
    chk("fl_idle", 32'(prefetch_idle), 32'd1);
    chk("fl_req_back", 32'(fetch_req), 32'd1);
    send_word(16'hABCD);
    chk("fl_after_inst", 32'(inst), 32'hABCD);
    chk("fl_after_imm", 32'(imm_full), 32'h00CD);

    // Push and pop in the same cycle
    start_fetch();
    beats(16'h2222, 0, 7);
    inst_done = 1'b1;
    beats(16'h2222, 7, 1);
    inst_done = 1'b0;
    chk("pp_inst", 32'(inst), 32'h2222);
    chk("pp_valid", 32'(inst_valid), 32'd1);
    chk("pp_not_full", 32'(fetch_req), 32'd1);
    chk("pp_imm", 32'(imm_full), 32'h0022);

    // Async reset during push and pop
    start_fetch();
    beats(16'h3333, 0, 7);
    inst_done = 1'b1; fetch_data_valid = 1'b1; fetch_data = 2'b11;
    #2 reset_n = 1'b0;
    #1;
    chk("ar_inst_valid", 32'(inst_valid), 32'd0);
    chk("ar_inst", 32'(inst), 32'h0);
    chk("ar_imm", 32'(imm_full), 32'h0);
    chk("ar_loaded", 32'(imm16_loaded), 32'd0);
    chk("ar_fetch_req", 32'(fetch_req), 32'd1);
    chk("ar_idle", 32'(prefetch_idle), 32'd1);
    inst_done = 1'b0; fetch_data_valid = 1'b0;
    #2 reset_n = 1'b1;
    tick();
    chk("ar_after_empty", 32'(inst_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
